acc_out_arbiter: RTL and testbench
==================================

// Module: acc_out_arbiter
// PURPOSE
//  Packet-level round-robin arbiter sharing the single command-out AXI-Stream among NUM_SLAVES accelerator outStreams.
//  Locks the grant for a whole packet (until TLAST) and tags each beat with the source index on m_tid.
//  Registers the output. Replaces the generic N:1 switch on the accelerator-to-manager return path.
// PARAMETERS
//  NUM_SLAVES   16  number of accelerator streams (>=1)
//  DATA_WIDTH   64  TDATA width
//  DEST_WIDTH   3   TDEST width, passed through unchanged
//  ID_WIDTH     $clog2(NUM_SLAVES), forced to 1 when that is 0; width of m_tid and the grant index
// PORTS
//  aclk         in   1                      clock, all logic on the rising edge
//  aresetn      in   1                      asynchronous active-low reset
//  s_tvalid     in   NUM_SLAVES             per-slave TVALID
//  s_tready     out  NUM_SLAVES             per-slave TREADY
//  s_tdata      in   NUM_SLAVES*DATA_WIDTH  slave i at bits [i*DATA_WIDTH +: DATA_WIDTH]
//  s_tdest      in   NUM_SLAVES*DEST_WIDTH  slave i at bits [i*DEST_WIDTH +: DEST_WIDTH]
//  s_tlast      in   NUM_SLAVES             per-slave TLAST
//  m_tvalid     out  1                      master TVALID (registered)
//  m_tready     in   1                      master TREADY
//  m_tdata      out  DATA_WIDTH             registered data
//  m_tid        out  ID_WIDTH               index of the granted slave
//  m_tdest      out  DEST_WIDTH             registered TDEST
//  m_tlast      out  1                      registered TLAST
//  busy         out  1                      1 while state==LOCK
// BEHAVIOUR
//  Reset (aresetn=0, async): state=IDLE, grant=0, rr_ptr=0, m_tvalid=0, m_tdata/m_tid/m_tdest/m_tlast=0, s_tready=0, busy=0.
//  FSM IDLE: s_tready=0. If any s_tvalid, grant<=first slave with s_tvalid searching rr_ptr, rr_ptr+1, ... (mod NUM_SLAVES). Go to LOCK.
//  FSM LOCK: s_tready[grant]=slot_free, where slot_free = !m_tvalid || m_tready. All other s_tready bits are 0.
//   Beat accepted when s_tvalid[grant] && s_tready[grant]. It loads the output register: m_tvalid<=1, m_tid<=grant.
//   If the accepted beat has s_tlast=1: state<=IDLE, rr_ptr<=(grant==NUM_SLAVES-1)?0:grant+1.
//  Output register: m_tvalid clears when m_tready=1 and no beat is accepted in that cycle. Data is held stable while m_tvalid && !m_tready.
//  Latency: s_tvalid rises in IDLE at cycle 0 -> s_tready high in cycle 1 -> m_tvalid high in cycle 2.
//   Full throughput of 1 beat/cycle inside a packet while m_tready=1.
//  Exactly one IDLE (bubble) cycle between consecutive packets.
//  No preemption. A granted slave that deasserts s_tvalid mid-packet keeps the grant indefinitely.
//  A new request in IDLE is the only arbitration point. A request arriving in LOCK waits.
//  Single-beat packet (tlast on the first beat): LOCK lasts exactly one accepting cycle.
//  NUM_SLAVES=1: rr_ptr stays 0, m_tid=0. Bubble behaviour is unchanged.
//  Reset mid-packet: the in-flight beat in the output register is dropped and arbitration restarts at slave 0.
//   The slave is responsible for restarting its packet.
// CONFIGURATION
//  ACC_ARB_FIXED_PRIO_EN defined: IDLE grants the lowest-index requesting slave; rr_ptr is unused and held at 0.
//  ACC_ARB_FIXED_PRIO_EN undefined (default): round-robin as described above.
// TESTING
//  1. Reset, slave 3 sends 1 beat (data=0xA, dest=2, last=1), m_tready=1 -> m_tvalid at cycle 2, data 0xA, tid 3, dest 2, last 1; busy low in cycle 3.
//  2. Slaves 0,5,9 each hold a 2-beat packet, m_tready=1 -> order 0,5,9 then 0 again; each packet's beats contiguous; 1 bubble between packets.
//  3. Slave 15 grants, packet of 4 beats, m_tready toggled 1,0,0,1,... -> no beat lost or duplicated, m_tdata stable while stalled, s_tready[15]=0 when slot full.
//  4. Slave 2 mid-packet drops s_tvalid 5 cycles while slave 1 requests -> slave 1 gets no grant until slave 2 tlast accepted.
//  5. aresetn pulsed low mid-packet on slave 7 -> m_tvalid=0 immediately; next grant with slaves 0 and 7 requesting goes to 0.
//  6. ACC_ARB_FIXED_PRIO_EN defined, slaves 1 and 4 continuously requesting -> slave 1 granted every time, slave 4 starved.

Source files
------------

// File: rtl/acc_out_arbiter.sv
// rtl/acc_out_arbiter.sv - packet-locked round-robin N:1 AXI-Stream arbiter with registered output
// Define ACC_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module acc_out_arbiter #(
  parameter int NUM_SLAVES = 16,
  parameter int DATA_WIDTH = 64,
  parameter int DEST_WIDTH = 3,
  parameter int ID_WIDTH   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [NUM_SLAVES-1:0]            s_tvalid,
  output logic [NUM_SLAVES-1:0]            s_tready,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_SLAVES*DEST_WIDTH-1:0] s_tdest,
  input  logic [NUM_SLAVES-1:0]            s_tlast,
  output logic                             m_tvalid,
  input  logic                             m_tready,
  output logic [DATA_WIDTH-1:0]            m_tdata,
  output logic [ID_WIDTH-1:0]              m_tid,
  output logic [DEST_WIDTH-1:0]            m_tdest,
  output logic                             m_tlast,
  output logic                             busy
);

  typedef enum logic {ST_IDLE, ST_LOCK} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ID_WIDTH-1:0]   r_grant;
  logic [ID_WIDTH-1:0]   r_rr_ptr;
  logic [ID_WIDTH-1:0]   w_pick;
  logic [ID_WIDTH-1:0]   w_cand;
  logic [ID_WIDTH:0]     w_sum;
  logic                  w_any_req;
  logic                  w_slot_free;
  logic                  w_accept;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_data;
  logic [DEST_WIDTH-1:0] w_dest;

  assign w_any_req   = |s_tvalid;
  assign w_slot_free = !m_tvalid || m_tready;
  assign w_last      = s_tlast[r_grant];
  assign w_accept    = (r_state == ST_LOCK) && s_tvalid[r_grant] && w_slot_free;
  assign busy        = (r_state == ST_LOCK);

  // Scan offsets from the far end so the requester closest to rr_ptr is written last and wins.
  always_comb begin
    w_pick = r_grant;
    w_sum  = '0;
    w_cand = '0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr_ptr} + (ID_WIDTH + 1)'(k);
      if (w_sum >= (ID_WIDTH + 1)'(NUM_SLAVES)) begin
        w_sum = w_sum - (ID_WIDTH + 1)'(NUM_SLAVES);
      end
      w_cand = w_sum[ID_WIDTH-1:0];
      if (s_tvalid[w_cand]) begin
        w_pick = w_cand;
      end
    end
  end

  always_comb begin
    w_data = '0;
    w_dest = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (r_grant == ID_WIDTH'(k)) begin
        w_data = s_tdata[k*DATA_WIDTH +: DATA_WIDTH];
        w_dest = s_tdest[k*DEST_WIDTH +: DEST_WIDTH];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    s_tready    = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = ST_LOCK;
        end
      end
      ST_LOCK: begin
        s_tready[r_grant] = w_slot_free;
        if (w_accept && w_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      if (r_state == ST_IDLE && w_any_req) begin
        r_grant <= w_pick;
      end
      if (w_accept && w_last) begin
`ifdef ACC_ARB_FIXED_PRIO_EN
        r_rr_ptr <= '0;
`else
        r_rr_ptr <= (r_grant == ID_WIDTH'(NUM_SLAVES - 1)) ? '0 : r_grant + 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tid    <= '0;
      m_tdest  <= '0;
      m_tlast  <= 1'b0;
    end else if (w_accept) begin
      m_tvalid <= 1'b1;
      m_tdata  <= w_data;
      m_tid    <= r_grant;
      m_tdest  <= w_dest;
      m_tlast  <= w_last;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_acc_out_arbiter.sv
// tb/tb_acc_out_arbiter.sv - scoreboard bench for acc_out_arbiter
module tb_acc_out_arbiter;
  localparam int NS  = 16;
  localparam int DW  = 64;
  localparam int DSW = 3;
  localparam int IW  = 4;

  typedef struct {
    logic [DW-1:0]  data;
    logic [DSW-1:0] dest;
    logic           last;
    logic [IW-1:0]  tid;
  } beat_t;

  logic             aclk = 1'b0;
  logic             aresetn = 1'b0;
  logic [NS-1:0]    s_tvalid;
  logic [NS-1:0]    s_tready;
  logic [NS*DW-1:0] s_tdata;
  logic [NS*DSW-1:0] s_tdest;
  logic [NS-1:0]    s_tlast;
  logic             m_tvalid;
  logic             m_tready;
  logic [DW-1:0]    m_tdata;
  logic [IW-1:0]    m_tid;
  logic [DSW-1:0]   m_tdest;
  logic             m_tlast;
  logic             busy;

  beat_t         sq [NS][$];
  beat_t         exp_q[$];
  int            hs_t[$];
  logic [NS-1:0] hold;
  logic [NS-1:0] acc;
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;

  acc_out_arbiter #(
    .NUM_SLAVES(NS), .DATA_WIDTH(DW), .DEST_WIDTH(DSW), .ID_WIDTH(IW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tdest(s_tdest), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tid(m_tid), .m_tdest(m_tdest), .m_tlast(m_tlast), .busy(busy)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic beat_t mk_beat(input int s, input int p, input int j, input int n);
    beat_t b;
    b.data = DW'(s * 256 + p * 16 + j);
    b.dest = DSW'(s + j);
    b.last = (j == n - 1);
    b.tid  = IW'(s);
    return b;
  endfunction

  task automatic send_pkt(input int s, input int p, input int n, input bit exp_out);
    for (int j = 0; j < n; j++) begin
      sq[s].push_back(mk_beat(s, p, j, n));
      if (exp_out) exp_q.push_back(mk_beat(s, p, j, n));
    end
  endtask

  task automatic exp_pkt(input int s, input int p, input int n);
    for (int j = 0; j < n; j++) exp_q.push_back(mk_beat(s, p, j, n));
  endtask

  function automatic int pending();
    int t;
    t = exp_q.size();
    for (int i = 0; i < NS; i++) t += sq[i].size();
    return t;
  endfunction

  task automatic tick;
    @(posedge aclk);
    #2;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (pending() != 0 && n < budget) begin
      tick;
      n++;
    end
    check(name, 64'(pending()), 64'd0);
    repeat (3) tick;
  endtask

  task automatic do_reset;
    aresetn  = 1'b0;
    hold     = '0;
    m_tready = 1'b1;
    for (int i = 0; i < NS; i++) sq[i].delete();
    exp_q.delete();
    repeat (2) tick;
    aresetn = 1'b1;
    tick;
  endtask

  // Slave models: present queue heads, pop what was accepted on the previous edge.
  initial begin
    beat_t b;
    s_tvalid = '0;
    s_tdata  = '0;
    s_tdest  = '0;
    s_tlast  = '0;
    forever begin
      @(negedge aclk);
      acc = s_tvalid & s_tready;
      @(posedge aclk);
      #1;
      for (int i = 0; i < NS; i++) begin
        if (acc[i] && sq[i].size() > 0) b = sq[i].pop_front();
        if (sq[i].size() > 0 && !hold[i]) begin
          s_tvalid[i]            = 1'b1;
          s_tdata[i*DW +: DW]    = sq[i][0].data;
          s_tdest[i*DSW +: DSW]  = sq[i][0].dest;
          s_tlast[i]             = sq[i][0].last;
        end else begin
          s_tvalid[i]            = 1'b0;
          s_tdata[i*DW +: DW]    = '0;
          s_tdest[i*DSW +: DSW]  = '0;
          s_tlast[i]             = 1'b0;
        end
      end
    end
  end

  // Monitor: compare every output handshake with the scoreboard head; check stalls.
  always @(negedge aclk) begin
    beat_t e;
    if (aresetn && m_tvalid) begin
      if (m_tready) begin
        hs_t.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat actual data=%0h tid=%0d required none", m_tdata, m_tid);
        end else begin
          e = exp_q.pop_front();
          if (m_tdata !== e.data || m_tid !== e.tid || m_tdest !== e.dest || m_tlast !== e.last) begin
            errors++;
            $display("FAIL out_beat actual data=%0h tid=%0d dest=%0d last=%0b required data=%0h tid=%0d dest=%0d last=%0b",
                     m_tdata, m_tid, m_tdest, m_tlast, e.data, e.tid, e.dest, e.last);
          end
        end
      end else begin
        check("stall_s_tready", 64'(s_tready), 64'd0);
        if (exp_q.size() > 0) check("stall_data_hold", m_tdata, exp_q[0].data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    hold     = '0;
    m_tready = 1'b1;
    repeat (3) @(posedge aclk);
    #2;
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_m_tdata", m_tdata, 64'd0);
    check("rst_m_tid", 64'(m_tid), 64'd0);
    check("rst_m_tdest_last", 64'({m_tdest, m_tlast}), 64'd0);
    check("rst_s_tready", 64'(s_tready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    aresetn = 1'b1;
    tick;

    // single beat on slave 3, latency profile
    sq[3].push_back('{data: 64'hA, dest: 3'd2, last: 1'b1, tid: 4'd3});
    exp_q.push_back('{data: 64'hA, dest: 3'd2, last: 1'b1, tid: 4'd3});
    @(posedge aclk);
    @(negedge aclk);
    check("t1_c0_s_tvalid3", 64'(s_tvalid[3]), 64'd1);
    check("t1_c0_s_tready", 64'(s_tready), 64'd0);
    @(negedge aclk);
    check("t1_c1_s_tready", 64'(s_tready), 64'h0008);
    check("t1_c1_busy", 64'(busy), 64'd1);
    check("t1_c1_m_tvalid", 64'(m_tvalid), 64'd0);
    @(negedge aclk);
    check("t1_c2_m_tvalid", 64'(m_tvalid), 64'd1);
    check("t1_c2_m_tid", 64'(m_tid), 64'd3);
    @(negedge aclk);
    check("t1_c3_busy", 64'(busy), 64'd0);
    check("t1_c3_m_tvalid", 64'(m_tvalid), 64'd0);
    tick;
    wait_drain("t1_drain", 50);

    // three requesters, order 0,5,9,0 with one bubble between packets
    do_reset;
    hs_t.delete();
    send_pkt(0, 0, 2, 1);
    send_pkt(5, 0, 2, 1);
    send_pkt(9, 0, 2, 1);
    send_pkt(0, 1, 2, 1);
    wait_drain("t2_drain", 100);
    check("t2_beats", 64'(hs_t.size()), 64'd8);
    if (hs_t.size() == 8) begin
      for (int k = 1; k < 8; k++) check("t2_gap", 64'(hs_t[k] - hs_t[k-1]), (k % 2 == 1) ? 64'd1 : 64'd2);
    end

    // backpressure on slave 15
    do_reset;
    send_pkt(15, 0, 4, 1);
    for (int k = 0; k < 24; k++) begin
      m_tready = (k % 4 == 0) || (k % 4 == 3);
      tick;
    end
    m_tready = 1'b1;
    wait_drain("t3_drain", 50);

    // no preemption while slave 2 idles mid-packet
    do_reset;
    send_pkt(2, 0, 3, 1);
    n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (!(s_tvalid[2] && s_tready[2]) && n < 50);
    check("t4_first_accept", 64'(n < 50), 64'd1);
    tick;
    hold[2] = 1'b1;
    send_pkt(1, 0, 1, 1);
    repeat (6) @(negedge aclk);
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      check("t4_s_tready1", 64'(s_tready[1]), 64'd0);
      check("t4_busy", 64'(busy), 64'd1);
    end
    hold[2] = 1'b0;
    tick;
    wait_drain("t4_drain", 60);

    // reset with a stalled beat from slave 7
    do_reset;
    m_tready = 1'b0;
    send_pkt(7, 0, 3, 0);
    repeat (5) tick;
    check("t5_pre_m_tvalid", 64'(m_tvalid), 64'd1);
    check("t5_pre_m_tid", 64'(m_tid), 64'd7);
    aresetn = 1'b0;
    #1;
    check("t5_rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("t5_rst_busy", 64'(busy), 64'd0);
    sq[7].delete();
    tick;
    tick;
    aresetn  = 1'b1;
    m_tready = 1'b1;
    tick;
    send_pkt(0, 0, 1, 1);
    send_pkt(7, 1, 2, 1);
    wait_drain("t5_drain", 60);

    // two continuous requesters
    do_reset;
    for (int r = 0; r < 3; r++) begin
      send_pkt(1, r, 1, 0);
      send_pkt(4, r, 1, 0);
    end
`ifdef ACC_ARB_FIXED_PRIO_EN
    for (int r = 0; r < 3; r++) exp_pkt(1, r, 1);
    for (int r = 0; r < 3; r++) exp_pkt(4, r, 1);
`else
    for (int r = 0; r < 3; r++) begin
      exp_pkt(1, r, 1);
      exp_pkt(4, r, 1);
    end
`endif
    wait_drain("t6_drain", 80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
